norm_shifter: RTL and testbench

NORM_SHIFTER -- requirements
Module: norm_shifter

---
 rtl/norm_shifter.sv | 114 +++++++++++
 tb/tb_norm_shifter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/norm_shifter.sv
// Two-stage normalization shifter: S1 computes shift amount and exponent, S2 applies the left barrel shift.
// Optional subnormal clamping is enabled by defining NORM_SUBNORMAL_CLAMP_EN.
module norm_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] mantissa_in,
    input  logic [9:0]  exponent_in,
    input  logic [4:0]  lz_count_in,
    input  logic        lz_zeros_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] mantissa_out,
    output logic [9:0]  exponent_out,
    output logic        zero_out,
    output logic        underflow_out
);

    localparam int unsigned MANT_W = 32;
    localparam int unsigned EXP_W  = 10;
    localparam int unsigned LZ_W   = 5;

    logic              s1_valid;
    logic [MANT_W-1:0] s1_mant;
    logic [LZ_W-1:0]   s1_shift;
    logic [EXP_W-1:0]  s1_exp;
    logic              s1_zero;
    logic              s1_uf;

    logic              s1_load;
    logic              s2_load;

    logic [MANT_W-1:0] mant_nxt;
    logic [LZ_W-1:0]   shift_nxt;
    logic [EXP_W-1:0]  exp_nxt;
    logic              uf_nxt;

    // out_valid doubles as the S2 valid bit
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

`ifdef NORM_SUBNORMAL_CLAMP_EN
    logic signed [EXP_W-1:0] exp_m1;
    logic [EXP_W-1:0]        shift_lim;
`endif

    // Shift amount, adjusted exponent and underflow for the incoming operand
    always_comb begin
        mant_nxt  = mantissa_in;
        shift_nxt = lz_count_in;
        exp_nxt   = exponent_in - EXP_W'(lz_count_in);
        uf_nxt    = 1'b0;
`ifdef NORM_SUBNORMAL_CLAMP_EN
        exp_m1    = $signed(exponent_in) - 10'sd1;
        shift_lim = (exp_m1 > 10'sd0) ? EXP_W'(exp_m1) : '0;
        if (EXP_W'(lz_count_in) > shift_lim) begin
            shift_nxt = LZ_W'(shift_lim);
            exp_nxt   = '0;
            uf_nxt    = 1'b1;
        end
`else
        uf_nxt    = ($signed(exp_nxt) < 10'sd1);
`endif
        if (lz_zeros_in) begin
            mant_nxt  = '0;
            shift_nxt = '0;
            exp_nxt   = '0;
            uf_nxt    = 1'b0;
        end
    end

    // Stage 1 register
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_shift <= '0;
            s1_exp   <= '0;
            s1_zero  <= 1'b0;
            s1_uf    <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mant  <= mant_nxt;
                s1_shift <= shift_nxt;
                s1_exp   <= exp_nxt;
                s1_zero  <= lz_zeros_in;
                s1_uf    <= uf_nxt;
            end
        end
    end

    // Stage 2: barrel shift into the output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            mantissa_out  <= '0;
            exponent_out  <= '0;
            zero_out      <= 1'b0;
            underflow_out <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                mantissa_out  <= s1_mant << s1_shift;
                exponent_out  <= s1_exp;
                zero_out      <= s1_zero;
                underflow_out <= s1_uf;
            end
        end
    end

endmodule

// File: tb/tb_norm_shifter.sv
// Self-checking bench for norm_shifter: directed vector table plus stall and reset sequences.
// Expectations follow the NORM_SUBNORMAL_CLAMP_EN setting of the build.
module tb_norm_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mantissa_in;
    logic [9:0]  exponent_in;
    logic [4:0]  lz_count_in;
    logic        lz_zeros_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] mantissa_out;
    logic [9:0]  exponent_out;
    logic        zero_out;
    logic        underflow_out;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    norm_shifter dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mantissa_in  (mantissa_in),
        .exponent_in  (exponent_in),
        .lz_count_in  (lz_count_in),
        .lz_zeros_in  (lz_zeros_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .mantissa_out (mantissa_out),
        .exponent_out (exponent_out),
        .zero_out     (zero_out),
        .underflow_out(underflow_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] mant;
        logic [9:0]  exp;
        logic [4:0]  lz;
        logic        zeros;
        logic [31:0] e_mant;
        logic [9:0]  e_exp;
        logic        e_zero;
        logic        e_uf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] pack_out();
        return {19'b0, out_valid, zero_out, underflow_out, exponent_out, mantissa_out};
    endfunction

    function automatic logic [63:0] pack_exp(input logic [31:0] m, input logic [9:0] e,
                                             input logic z, input logic u);
        return {19'b0, 1'b1, z, u, e, m};
    endfunction

    task automatic drive_op(input logic [31:0] m, input logic [9:0] e,
                            input logic [4:0] lz, input logic z);
        in_valid    = 1'b1;
        mantissa_in = m;
        exponent_in = e;
        lz_count_in = lz;
        lz_zeros_in = z;
    endtask

    logic [63:0] held;
    logic        stalled_prev;
    logic        saw_block;
    logic        saw_valid;
    int          sent;
    int          got;

    initial begin
        vecs[0] = '{32'h00F00000, 10'd100,  5'd8,  1'b0, 32'hF0000000, 10'd92,  1'b0, 1'b0};
        vecs[1] = '{32'h00000000, 10'd50,   5'd5,  1'b1, 32'h00000000, 10'd0,   1'b1, 1'b0};
        vecs[3] = '{32'h80000000, 10'd1,    5'd0,  1'b0, 32'h80000000, 10'd1,   1'b0, 1'b0};
        vecs[6] = '{32'h0000FFFF, 10'd511,  5'd16, 1'b0, 32'hFFFF0000, 10'h1EF, 1'b0, 1'b0};
        vecs[7] = '{32'h12345678, 10'h338,  5'd3,  1'b1, 32'h00000000, 10'd0,   1'b1, 1'b0};
        vecs[8] = '{32'h00000003, 10'd31,   5'd30, 1'b0, 32'hC0000000, 10'd1,   1'b0, 1'b0};
`ifdef NORM_SUBNORMAL_CLAMP_EN
        vecs[2] = '{32'h00000001, 10'd10,   5'd31, 1'b0, 32'h00000200, 10'd0,   1'b0, 1'b1};
        vecs[4] = '{32'h40000000, 10'd1,    5'd1,  1'b0, 32'h40000000, 10'd0,   1'b0, 1'b1};
        vecs[5] = '{32'h00012345, 10'h39C,  5'd15, 1'b0, 32'h00012345, 10'd0,   1'b0, 1'b1};
        vecs[9] = '{32'h00000003, 10'd30,   5'd30, 1'b0, 32'h60000000, 10'd0,   1'b0, 1'b1};
`else
        vecs[2] = '{32'h00000001, 10'd10,   5'd31, 1'b0, 32'h80000000, 10'h3EB, 1'b0, 1'b1};
        vecs[4] = '{32'h40000000, 10'd1,    5'd1,  1'b0, 32'h80000000, 10'd0,   1'b0, 1'b1};
        vecs[5] = '{32'h00012345, 10'h39C,  5'd15, 1'b0, 32'h91A28000, 10'h38D, 1'b0, 1'b1};
        vecs[9] = '{32'h00000003, 10'd30,   5'd30, 1'b0, 32'hC0000000, 10'd0,   1'b0, 1'b1};
`endif

        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        mantissa_in = '0;
        exponent_in = '0;
        lz_count_in = '0;
        lz_zeros_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", pack_out(), 64'h0);
        reset = 1'b0;
        check("in_ready_after_reset", {63'b0, in_ready}, 64'h1);

        // Directed vectors, one at a time with out_ready high
        for (int i = 0; i < 10; i++) begin
            drive_op(vecs[i].mant, vecs[i].exp, vecs[i].lz, vecs[i].zeros);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check($sformatf("latency_v%0d", i), {63'b0, out_valid}, 64'h0);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), pack_out(),
                  pack_exp(vecs[i].e_mant, vecs[i].e_exp, vecs[i].e_zero, vecs[i].e_uf));
        end
        @(posedge clk); #1;

        // Eight back-to-back operands with a four-cycle downstream stall
        sent = 0; got = 0; stalled_prev = 1'b0; saw_block = 1'b0; held = '0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            if (sent < 8) drive_op(32'h00010000 | 32'(sent), 10'(100 + sent), 5'd15, 1'b0);
            else in_valid = 1'b0;
            @(negedge clk);
            if (stalled_prev) check("stall_hold", pack_out(), held);
            stalled_prev = out_valid && !out_ready;
            held = pack_out();
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                check($sformatf("stream%0d", got), pack_out(),
                      pack_exp(32'h80000000 | (32'(got) << 15), 10'(85 + got), 1'b0, 1'b0));
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 64'(got), 64'd8);
        check("stream_sent", 64'(sent), 64'd8);
        check("in_ready_dropped", {63'b0, saw_block}, 64'h1);
        saw_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("no_duplicate", {63'b0, saw_valid}, 64'h0);

        // Reset with two operands in flight and a concurrent handshake
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive_op(32'h00F00000, 10'd100, 5'd8, 1'b0);
        @(posedge clk); #1;
        drive_op(32'h0000FFFF, 10'd200, 5'd16, 1'b0);
        @(posedge clk); #1;
        check("preflight_valid", {63'b0, out_valid}, 64'h1);
        reset     = 1'b1;
        out_ready = 1'b1;
        drive_op(32'h00000001, 10'd300, 5'd31, 1'b0);
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check("reset_midflight", {pack_out()[62:0], in_ready}, 64'h1);
        saw_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("no_stale_result", {63'b0, saw_valid}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
